dcache_ctrl: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate L1 data cache controller, one word per line.

---
 rtl/dcache_pkg.sv | 33 +++
 rtl/dcache_line_array.sv | 44 ++++
 rtl/dcache_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped write-through L1 data cache:
//   - default geometry (INDEX_BITS_DEF, TAG_BITS_DEF)
//   - controller state encoding (dcache_state_e)
//   - a line view type (dcache_line_t) for the default geometry
//   - sat_inc(): saturating 32-bit increment used by the hit/miss counters
// -----------------------------------------------------------------------------
package dcache_pkg;

    localparam int INDEX_BITS_DEF = 6;
    // Word-addressed 32-bit space: tag + index + 2 byte-offset bits = 32.
    localparam int TAG_BITS_DEF   = 30 - INDEX_BITS_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MISS_RD = 2'd1,
        WR_THRU = 2'd2,
        DONE    = 2'd3
    } dcache_state_e;

    typedef struct packed {
        logic                    valid;
        logic [TAG_BITS_DEF-1:0] tag;
        logic [31:0]             data;
    } dcache_line_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// -----------------------------------------------------------------------------
// dcache_line_array
// Tag and data storage for the cache lines. Asynchronous read so the hit
// compare and load-hit data are available in the request cycle; one
// synchronous write port shared by store-hit updates and miss refills.
// Contents are not reset (validity is tracked by the controller).
// Ports:
//   clk      clock
//   rd_idx   read line index          rd_tag/rd_data  read tag/data
//   wr_en    write strobe             wr_idx          write line index
//   wr_tag   tag to write             wr_data         data to write
// -----------------------------------------------------------------------------
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_BITS   = TAG_BITS_DEF
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_tag  = tag_mem[rd_idx];
    assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-through, no-write-allocate L1 data cache controller,
// one 32-bit word per line. Load hits return in the request cycle; load
// misses and all stores issue one single-word bus transaction, followed by a
// DONE cycle that keeps mem_req low so the master's trailing ready is ignored.
// Ports:
//   clk, rst (async, active-low)
//   core_req/core_write/core_addr/core_wdata  CPU request (held while stalled)
//   core_rdata/core_stall                     CPU response
//   flush                                     invalidate all lines (IDLE only)
//   mem_req/mem_write/mem_addr/mem_wdata      bus master request (registered)
//   mem_rdata/mem_ready                       bus master response
//   hit_cnt/miss_cnt                          saturating read hit/miss counters
// -----------------------------------------------------------------------------
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_BITS   = TAG_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_write,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int LINES = 1 << INDEX_BITS;

    dcache_state_e         state_reg;
    logic [LINES-1:0]      valid_reg;
    logic [LINES-1:0]      valid_next;
    logic                  mem_req_reg;
    logic                  mem_write_reg;
    logic [31:0]           mem_addr_reg;
    logic [31:0]           mem_wdata_reg;
    logic [31:0]           rdata_q_reg;
    logic [31:0]           hit_cnt_reg;
    logic [31:0]           miss_cnt_reg;

    logic [INDEX_BITS-1:0] req_idx, refill_idx, wr_idx;
    logic [TAG_BITS-1:0]   req_tag, refill_tag, wr_tag, rd_tag;
    logic [31:0]           rd_data, wr_data;
    logic                  is_idle, hit, mem_done, store_hit, refill, wr_en;
    logic                  unused_addr_bits;

    assign req_idx    = core_addr[INDEX_BITS+1:2];
    assign req_tag    = core_addr[31:32-TAG_BITS];
    // The refill target comes from the registered bus address, which is the
    // address the miss was issued for.
    assign refill_idx = mem_addr_reg[INDEX_BITS+1:2];
    assign refill_tag = mem_addr_reg[31:32-TAG_BITS];
    assign unused_addr_bits = ^core_addr[1:0];

    assign is_idle   = (state_reg == IDLE);
    assign hit       = valid_reg[req_idx] && (rd_tag == req_tag);
    assign mem_done  = mem_req_reg && mem_ready;
    assign store_hit = is_idle && core_req && core_write && hit;
    assign refill    = (state_reg == MISS_RD) && mem_done;

    // Single write port: refill has priority (the two never coincide since
    // one happens in MISS_RD and the other in IDLE). A store hit rewrites the
    // matching tag unchanged.
    assign wr_en   = store_hit || refill;
    assign wr_idx  = refill ? refill_idx : req_idx;
    assign wr_tag  = refill ? refill_tag : req_tag;
    assign wr_data = refill ? mem_rdata  : core_wdata;

    dcache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk     (clk),
        .rd_idx  (req_idx),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_tag  (wr_tag),
        .wr_data (wr_data)
    );

    // Flush wins over a refill set, but the two cannot overlap (flush is only
    // honoured in IDLE, refill happens in MISS_RD).
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            assign valid_next[gi] = (is_idle && flush) ? 1'b0 :
                                    (refill && (refill_idx == INDEX_BITS'(gi))) ? 1'b1 :
                                    valid_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rdata_q_reg   <= '0;
            hit_cnt_reg   <= '0;
            miss_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (core_req) begin
                        if (core_write) begin
                            mem_req_reg   <= 1'b1;
                            mem_write_reg <= 1'b1;
                            mem_addr_reg  <= {req_tag, req_idx, 2'b00};
                            mem_wdata_reg <= core_wdata;
                            state_reg     <= WR_THRU;
                        end else if (!hit) begin
                            mem_req_reg   <= 1'b1;
                            mem_write_reg <= 1'b0;
                            mem_addr_reg  <= {req_tag, req_idx, 2'b00};
                            miss_cnt_reg  <= sat_inc(miss_cnt_reg);
                            state_reg     <= MISS_RD;
                        end else begin
                            hit_cnt_reg   <= sat_inc(hit_cnt_reg);
                        end
                    end
                end
                MISS_RD: begin
                    if (mem_done) begin
                        rdata_q_reg <= mem_rdata;
                        mem_req_reg <= 1'b0;
                        state_reg   <= DONE;
                    end
                end
                WR_THRU: begin
                    if (mem_done) begin
                        mem_req_reg   <= 1'b0;
                        mem_write_reg <= 1'b0;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign core_stall = (state_reg == MISS_RD) || (state_reg == WR_THRU) ||
                        (is_idle && core_req && (core_write || !hit));
    assign core_rdata = (is_idle && hit) ? rd_data : rdata_q_reg;

    assign mem_req   = mem_req_reg;
    assign mem_write = mem_write_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign hit_cnt   = hit_cnt_reg;
    assign miss_cnt  = miss_cnt_reg;

endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
// Scoreboard bench for dcache_ctrl. Stimulus pushes the expected load data and
// expected bus transactions into queues; monitors pop and compare whenever the
// DUT completes a load or a bus transaction. A simple bus master model adds a
// fixed wait of BUS_LAT cycles and keeps a word memory updated by writes.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

    localparam int BUS_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req, core_write, flush;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        mem_req, mem_write, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] hit_cnt, miss_cnt;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];

    logic [31:0] bus_mem [0:16383];
    int          bus_cnt = 0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_write (core_write),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    // Bus master model: ready is high while idle with Req low, low while
    // waiting, and high for the completing cycle after BUS_LAT wait cycles.
    assign mem_ready = mem_req ? (bus_cnt == BUS_LAT) : 1'b1;
    assign mem_rdata = bus_mem[mem_addr[15:2]];

    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_write)
            bus_mem[mem_addr[15:2]] <= mem_wdata;
        if (!mem_req || mem_ready)
            bus_cnt <= 0;
        else
            bus_cnt <= bus_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitors: one load response and one bus completion are checked per event.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        bus_t        b;
        if (rst) begin
            if (core_req && !core_write && !core_stall) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    $display("FAIL rdata_unexpected: got %h with no load expected", core_rdata);
                end else begin
                    e = exp_rd.pop_front();
                    chk("core_rdata", core_rdata, e);
                end
            end
            if (mem_req && mem_ready) begin
                if (exp_bus.size() == 0) begin
                    checks++;
                    $display("FAIL bus_unexpected: got addr %h write %0b with no transaction expected",
                             mem_addr, mem_write);
                end else begin
                    b = exp_bus.pop_front();
                    chk("bus_write", {31'd0, mem_write}, {31'd0, b.w});
                    chk("bus_addr", mem_addr, b.a);
                    if (b.w) chk("bus_wdata", mem_wdata, b.d);
                end
            end
        end
    end

    // One CPU access: hold the request until the DUT releases stall, count the
    // stalled cycles and compare with the expected count.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic fl, input int exp_stall, input logic [31:0] exp_data,
                          input string nm);
        int stalls = 0;
        bit done   = 1'b0;
        @(posedge clk); #1;
        core_req   = 1'b1;
        core_write = wr;
        core_addr  = addr;
        core_wdata = wd;
        flush      = fl;
        if (!wr) exp_rd.push_back(exp_data);
        if (wr || exp_stall != 0) exp_bus.push_back('{w: wr, a: addr, d: wd});
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!core_stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done) begin
            checks++;
            $display("FAIL %s_timeout: stall still high after %0d cycles", nm, stalls);
        end
        chk({nm, "_stall"}, 32'(stalls), 32'(exp_stall));
        $display("txn %s: %s addr=%h wdata=%h stall=%0d rdata=%h", nm, wr ? "store" : "load",
                 addr, wd, stalls, core_rdata);
        @(posedge clk); #1;
        core_req = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        core_req = 1'b0; core_write = 1'b0; flush = 1'b0;
        core_addr = '0; core_wdata = '0;
        for (int i = 0; i < 16384; i++) bus_mem[i] = 32'h0;
        bus_mem[32'h100 >> 2]  = 32'hDEAD_BEEF;
        bus_mem[32'h4100 >> 2] = 32'hCAFE_0001;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_core_stall", {31'd0, core_stall}, 32'd0);
        chk("rst_core_rdata", core_rdata, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        rst = 1'b1;

        // 1: cold load miss
        access(1'b0, 32'h100, 32'h0, 1'b0, 5, 32'hDEAD_BEEF, "t1_load_miss");
        chk("t1_miss_cnt", miss_cnt, 32'd1);
        chk("t1_hit_cnt", hit_cnt, 32'd0);

        // 2: load hit
        access(1'b0, 32'h100, 32'h0, 1'b0, 0, 32'hDEAD_BEEF, "t2_load_hit");
        chk("t2_hit_cnt", hit_cnt, 32'd1);

        // 3: store hit updates the line, load hits with new data
        access(1'b1, 32'h100, 32'h1234_5678, 1'b0, 5, 32'h0, "t3_store_hit");
        access(1'b0, 32'h100, 32'h0, 1'b0, 0, 32'h1234_5678, "t3_load_hit");
        chk("t3_hit_cnt", hit_cnt, 32'd2);

        // 4: store miss does not allocate
        access(1'b1, 32'h200, 32'hAAAA_5555, 1'b0, 5, 32'h0, "t4_store_miss");
        access(1'b0, 32'h200, 32'h0, 1'b0, 5, 32'hAAAA_5555, "t4_load_miss");
        chk("t4_miss_cnt", miss_cnt, 32'd2);

        // 5: conflicting tag replaces the line; flush invalidates
        access(1'b0, 32'h4100, 32'h0, 1'b0, 5, 32'hCAFE_0001, "t5_conflict");
        access(1'b0, 32'h100, 32'h0, 1'b0, 5, 32'h1234_5678, "t5_evicted");
        access(1'b0, 32'h4100, 32'h0, 1'b0, 5, 32'hCAFE_0001, "t5_refetch");
        access(1'b0, 32'h4100, 32'h0, 1'b0, 0, 32'hCAFE_0001, "t5_hit");
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        access(1'b0, 32'h4100, 32'h0, 1'b0, 5, 32'hCAFE_0001, "t5_after_flush");
        // flush together with a hit: the hit uses pre-flush valid bits
        access(1'b0, 32'h4100, 32'h0, 1'b1, 0, 32'hCAFE_0001, "t5_flush_hit");
        access(1'b0, 32'h4100, 32'h0, 1'b0, 5, 32'hCAFE_0001, "t5_post_flush");
        chk("t5_hit_cnt", hit_cnt, 32'd4);
        chk("t5_miss_cnt", miss_cnt, 32'd7);

        // 6: reset in the middle of a miss
        @(posedge clk); #1;
        core_req = 1'b1; core_write = 1'b0; core_addr = 32'h100;
        begin : wait_req
            bit seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (mem_req) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("t6_mem_req_seen", {31'd0, seen}, 32'd1);
        end
        #2 rst = 1'b0;
        #1;
        chk("t6_mem_req_async", {31'd0, mem_req}, 32'd0);
        chk("t6_miss_cnt_rst", miss_cnt, 32'd0);
        core_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        access(1'b0, 32'h100, 32'h0, 1'b0, 5, 32'h1234_5678, "t6_after_rst");
        chk("t6_miss_cnt", miss_cnt, 32'd1);
        chk("t6_hit_cnt", hit_cnt, 32'd0);

        repeat (3) @(posedge clk);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
